// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared state type, error codes and instruction field offsets for the decode controller
package decode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_WAIT,
    ST_FINISH
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam int OPCODE_W = 5;
  localparam int FLAG_W   = 2;

  // Fields packed MSB to LSB: flag, opcode, rd, rs1, rs2, pc, imm (imm sits at bit 0)
  function automatic int pc_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int rs2_lsb(input int pc_w, input int data_w);
    return pc_w + data_w;
  endfunction

  function automatic int rs1_lsb(input int addr_w, input int pc_w, input int data_w);
    return addr_w + pc_w + data_w;
  endfunction

  function automatic int rd_lsb(input int addr_w, input int pc_w, input int data_w);
    return 2 * addr_w + pc_w + data_w;
  endfunction

  function automatic int opcode_lsb(input int addr_w, input int pc_w, input int data_w);
    return 3 * addr_w + pc_w + data_w;
  endfunction

  function automatic int flag_lsb(input int addr_w, input int pc_w, input int data_w);
    return opcode_lsb(addr_w, pc_w, data_w) + OPCODE_W;
  endfunction

  function automatic int instr_w(input int addr_w, input int pc_w, input int data_w);
    return flag_lsb(addr_w, pc_w, data_w) + FLAG_W;
  endfunction

endpackage

// File: rtl/decode_timeout_counter.sv
// rtl/decode_timeout_counter.sv - counts cycles spent waiting on a unit and flags when the budget is used up
module decode_timeout_counter #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count_q;

  // The current cycle counts toward the budget, so expiry fires in the TIMEOUT_CYC-th enabled cycle
  assign expired = enable && (count_q >= LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multi_unit_decode_controller.sv
// rtl/multi_unit_decode_controller.sv - decodes one instruction, dispatches it to an execution unit and reports completion
module multi_unit_decode_controller
  import decode_pkg::*;
#(
  parameter int NUM_UNITS   = 4,
  parameter int ADDR_W      = 5,
  parameter int PC_W        = 5,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [instr_w(ADDR_W, PC_W, DATA_W)-1:0]  instruction,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      fetch_stage_enable,
  output logic [PC_W-1:0]                           next_pc_to_cpu,
  output logic [1:0]                                err_code,
  output logic [NUM_UNITS-1:0]                      unit_start,
  input  logic [NUM_UNITS-1:0]                      unit_busy,
  input  logic [NUM_UNITS-1:0]                      unit_done,
  input  logic [NUM_UNITS*PC_W-1:0]                 unit_next_pc,
  output logic [1:0]                                op_type,
  output logic [ADDR_W-1:0]                         dst_addr,
  output logic [ADDR_W-1:0]                         src1_addr,
  output logic [ADDR_W-1:0]                         src2_addr,
  output logic [PC_W-1:0]                           pc,
  output logic [DATA_W-1:0]                         imm
);

  localparam int SEL_W   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int PC_LSB  = pc_lsb(DATA_W);
  localparam int RS2_LSB = rs2_lsb(PC_W, DATA_W);
  localparam int RS1_LSB = rs1_lsb(ADDR_W, PC_W, DATA_W);
  localparam int RD_LSB  = rd_lsb(ADDR_W, PC_W, DATA_W);
  localparam int OP_LSB  = opcode_lsb(ADDR_W, PC_W, DATA_W);
  localparam int FL_LSB  = flag_lsb(ADDR_W, PC_W, DATA_W);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q;
  logic [OPCODE_W-1:0] opcode_in;
  logic [PC_W-1:0]     pc_in;
  logic                legal;
  logic                accept, capture, timed_out, expired;
  logic                sel_busy, sel_done;

  assign opcode_in = instruction[OP_LSB +: OPCODE_W];
  assign pc_in     = instruction[PC_LSB +: PC_W];
  assign legal     = (32'(opcode_in) < NUM_UNITS);

  // Only the selected unit's handshake matters; every other unit is ignored
  assign sel_busy = unit_busy[sel_q];
  assign sel_done = unit_done[sel_q];

  assign busy               = (state_q == ST_DISPATCH) || (state_q == ST_WAIT);
  assign done               = (state_q == ST_FINISH);
  assign fetch_stage_enable = !busy;
  assign unit_start         = (state_q == ST_DISPATCH) ? (NUM_UNITS'(1) << sel_q) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    capture   = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = legal ? ST_DISPATCH : ST_FINISH;
        end
      end
      ST_DISPATCH: begin
        if (expired) begin
          timed_out = 1'b1;
          state_d   = ST_FINISH;
        end else if (sel_busy) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Expiry wins over a completion arriving in the same cycle
        if (expired) begin
          timed_out = 1'b1;
          state_d   = ST_FINISH;
        end else if (sel_done && !sel_busy) begin
          capture = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_type        <= '0;
      dst_addr       <= '0;
      src1_addr      <= '0;
      src2_addr      <= '0;
      pc             <= '0;
      imm            <= '0;
      sel_q          <= '0;
      err_code       <= ERR_NONE;
      next_pc_to_cpu <= '0;
    end else begin
      if (accept) begin
        op_type   <= instruction[FL_LSB +: FLAG_W];
        dst_addr  <= instruction[RD_LSB +: ADDR_W];
        src1_addr <= instruction[RS1_LSB +: ADDR_W];
        src2_addr <= instruction[RS2_LSB +: ADDR_W];
        pc        <= pc_in;
        imm       <= instruction[DATA_W-1:0];
        sel_q     <= opcode_in[SEL_W-1:0];
        err_code  <= legal ? ERR_NONE : ERR_ILLEGAL;
        if (!legal) begin
          next_pc_to_cpu <= pc_in + PC_W'(1);
        end
      end
      if (timed_out) begin
        err_code       <= ERR_TIMEOUT;
        next_pc_to_cpu <= pc + PC_W'(1);
      end
      if (capture) begin
        next_pc_to_cpu <= unit_next_pc[32'(sel_q)*PC_W +: PC_W];
      end
    end
  end

  decode_timeout_counter #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (busy),
    .expired(expired)
  );

endmodule

// File: doc/multi_unit_decode_controller.md
MULTI_UNIT_DECODE_CONTROLLER -- requirements
Module: multi_unit_decode_controller

Interface
REQ-001 Parameter NUM_UNITS, default 4, number of execution sub-controllers; opcode k selects unit k.
REQ-002 Parameter ADDR_W, default 5, register-address width.
REQ-003 Parameter PC_W, default 5, program-counter width.
REQ-004 Parameter DATA_W, default 32, immediate width.
REQ-005 Parameter TIMEOUT_CYC, default 255, maximum cycles spent in DISPATCH plus WAIT before abort.
REQ-006 Derived INSTR_W = 2+5+3*ADDR_W+PC_W+DATA_W (59 at defaults); fields MSB to LSB are flag[1:0], opcode[4:0], rd, rs1, rs2, pc, imm.
REQ-007 clk  in  1  sole clock; all logic on the rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  CPU request to decode instruction; sampled only in IDLE.
REQ-010 instruction  in  INSTR_W  instruction word, valid when start=1.
REQ-011 busy  out  1  high from the cycle after start is accepted until completion.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 fetch_stage_enable  out  1  CPU poll flag; low while an instruction is in flight.
REQ-014 next_pc_to_cpu  out  PC_W  PC for the next fetch.
REQ-015 err_code  out  2  0 none, 1 illegal opcode, 2 timeout; held until the next accepted start.
REQ-016 unit_start  out  NUM_UNITS  one-hot start to the selected unit.
REQ-017 unit_busy, unit_done  in  NUM_UNITS each  per-unit status.
REQ-018 unit_next_pc  in  NUM_UNITS*PC_W  per-unit next PC; slice k belongs to unit k.
REQ-019 op_type(2), dst_addr, src1_addr, src2_addr (ADDR_W), pc (PC_W), imm (DATA_W)  out  broadcast operand bus to all units, registered.

Function
REQ-020 The FSM SHALL have states IDLE, DISPATCH, WAIT, FINISH.
REQ-021 IDLE with start=1: latch all fields onto the operand bus, set busy=1, fetch_stage_enable=0, err_code=0, clear the timer; go to DISPATCH if opcode<NUM_UNITS, otherwise go to FINISH with err_code=1.
REQ-022 In DISPATCH, unit_start[opcode] SHALL be 1 and all other bits 0; on the first cycle unit_busy[opcode]=1, drop unit_start and go to WAIT.
REQ-023 WAIT: when unit_done[opcode]=1 and unit_busy[opcode]=0, capture the unit_next_pc slice for that unit into next_pc_to_cpu and go to FINISH.
REQ-024 FINISH (one cycle): done=1, busy=0, fetch_stage_enable=1; return to IDLE. Start SHALL NOT be accepted in FINISH.
REQ-025 On an illegal opcode or timeout, next_pc_to_cpu SHALL be (latched pc+1) mod 2^PC_W; 31 wraps to 0 at default width.
REQ-026 The timer SHALL count every cycle in DISPATCH and WAIT; on reaching TIMEOUT_CYC, force unit_start=0, set err_code=2, and go to FINISH; a timeout takes precedence over a same-cycle unit_done.
REQ-027 Minimum legal latency: start to done is 3 cycles when the unit is busy one cycle after start and done one cycle after that.
REQ-028 unit_busy/unit_done of unselected units SHALL be ignored.
REQ-029 start while busy=1 SHALL be ignored, with no effect on the latched fields.

Reset
REQ-030 rst low SHALL immediately force IDLE, busy=0, done=0, fetch_stage_enable=1, next_pc_to_cpu=0, err_code=0, unit_start=0, operand bus=0, timer=0.
REQ-031 Reset mid-operation SHALL abandon the instruction with no done pulse; the first start after release SHALL be accepted normally.

Structure
REQ-032 Package decode_pkg SHALL hold the state enum, err_code constants, and field-offset functions of ADDR_W/PC_W/DATA_W.
REQ-033 The timer SHALL be sub-module decode_timeout_counter (clear, enable, expired output, parameter TIMEOUT_CYC).
REQ-034 The register file and execution units are external and SHALL NOT be instantiated here.

Verification
REQ-035 ADD case: opcode 0, pc=7, unit 0 busy at +1 and done at +2 with next_pc 8 -> unit_start[0] for 1 cycle, done at cycle 3, next_pc_to_cpu=8, err_code=0.
REQ-036 Illegal opcode 9, pc=31 -> no unit_start, done after 1 cycle, err_code=1, next_pc_to_cpu=0.
REQ-037 Opcode 2 with the unit never busy, TIMEOUT_CYC=8 -> unit_start[2] held 8 cycles then drops, err_code=2, next_pc=pc+1.
REQ-038 start re-pulsed with a different instruction during WAIT -> ignored; the result matches the first instruction.
REQ-039 rst low during WAIT -> outputs at reset values the same cycle, no done pulse; a following instruction completes correctly.
REQ-040 unit_done[1] asserted while unit 3 is selected -> ignored; completion occurs only on unit 3's handshake.
